if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 69 ++++++
 tb/tb_if_id_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: show-ahead circular FIFO of {pc, insn}
// with full back-pressure to fetch and single-cycle flush on taken branches.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_en,
  input  logic [31:0]                if_pc,
  input  logic [31:0]                if_insn,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       if_stall,
  output logic                       id_valid,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_insn,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr_p0;
  logic [AW-1:0] r_rptr_p0;
  logic [CW-1:0] r_count_p0;

  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count_p0 == CW'(DEPTH));
  assign w_valid = (r_count_p0 != '0);
  // A full queue refuses the push even when a pop frees a slot this cycle.
  assign w_push  = if_en & ~w_full & ~flush;
  assign w_pop   = w_valid & id_ready & ~flush;

  // Storage: only accepted pushes touch the array, contents are never reset.
  always_ff @(posedge clk) begin
    if (w_push && !reset)
      r_mem[r_wptr_p0] <= {if_pc, if_insn};
  end

  // Control: pointers and occupancy; reset outranks flush, flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr_p0  <= '0;
      r_rptr_p0  <= '0;
      r_count_p0 <= '0;
    end else begin
      if (w_push)
        r_wptr_p0 <= r_wptr_p0 + AW'(1);
      if (w_pop)
        r_rptr_p0 <= r_rptr_p0 + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count_p0 <= r_count_p0 + CW'(1);
        2'b01:   r_count_p0 <= r_count_p0 - CW'(1);
        default: r_count_p0 <= r_count_p0;
      endcase
    end
  end

  // Show-ahead head; zeroed while empty so stale array data never leaks.
  assign if_stall = w_full;
  assign id_valid = w_valid;
  assign id_pc    = w_valid ? r_mem[r_rptr_p0][63:32] : 32'h0;
  assign id_insn  = w_valid ? r_mem[r_rptr_p0][31:0]  : 32'h0;
  assign count    = r_count_p0;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: stimulus queues expected entries, a negedge
// monitor checks each delivered head against that scoreboard.
module tb_if_id_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_en = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_insn = '0;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;
  logic        if_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_insn;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  logic [63:0] sb [$];

  if_id_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .if_en(if_en), .if_pc(if_pc), .if_insn(if_insn),
    .flush(flush), .id_ready(id_ready), .if_stall(if_stall), .id_valid(id_valid),
    .id_pc(id_pc), .id_insn(id_insn), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; returns #1 after the edge so outputs reflect the new state.
  task automatic cyc(input logic en, input logic [31:0] pc, input logic [31:0] insn,
                     input logic rdy, input logic fl, input logic rs, input bit exp_push);
    if_en = en; if_pc = pc; if_insn = insn; id_ready = rdy; flush = fl; reset = rs;
    if (fl || rs) sb.delete();
    if (exp_push) sb.push_back({pc, insn});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: a pop happens at the next edge exactly when the DUT shows valid+ready.
  always @(negedge clk) begin
    if (mon_en && !reset && !flush) begin
      if (id_valid && id_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL head_unexpected: got pc=%0h insn=%0h expected no entry", id_pc, id_insn);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          if ({id_pc, id_insn} !== e) begin
            n_fail++;
            $display("FAIL head_order: got pc=%0h insn=%0h expected pc=%0h insn=%0h",
                     id_pc, id_insn, e[63:32], e[31:0]);
          end
        end
      end
      if (!id_valid) chk("empty_zero", {id_pc, id_insn}, 64'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    mon_en = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_stall", if_stall, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_head", {id_pc, id_insn}, 64'h0);

    // Fill with id_ready=0
    cyc(1'b1, 32'h00, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("push_latency_valid", id_valid, 1);
    chk("push_latency_head", {id_pc, id_insn}, {32'h00, 32'h11});
    cyc(1'b1, 32'h04, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h08, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0C, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fill_count", count, 4);
    chk("fill_stall", if_stall, 1);
    cyc(1'b1, 32'h10, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("refused_count", count, 4);
    chk("refused_head", id_pc, 32'h00);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("drain_count", count, 3 - i);
    end
    chk("drain_valid", id_valid, 0);
    chk("drain_head", {id_pc, id_insn}, 64'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ready_on_empty", count, 0);

    // Wrap-around: simultaneous push/pop keeps count at 1
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'(i * 4), 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      chk("wrap_count", count, 1);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_final_count", count, 0);

    // Full plus pop: pop happens, push refused, then accepted on re-presentation
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'(i * 4), 32'h51 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full2_stall", if_stall, 1);
    cyc(1'b1, 32'h10, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fullpop_count", count, 3);
    chk("fullpop_stall", if_stall, 0);
    chk("fullpop_head", id_pc, 32'h04);
    cyc(1'b1, 32'h10, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("repush_count", count, 4);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fullpop_drained", count, 0);

    // Flush with push and pop in the same cycle
    cyc(1'b1, 32'h20, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h24, 32'hA4, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h28, 32'hA8, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("preflush_count", count, 3);
    cyc(1'b1, 32'h2C, 32'hAC, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_valid", id_valid, 0);
    cyc(1'b1, 32'h40, 32'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("postflush_count", count, 1);
    chk("postflush_head", {id_pc, id_insn}, {32'h40, 32'h99});
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush while full releases the stall
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h80 + 32'(i * 4), 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full3_stall", if_stall, 1);
    cyc(1'b1, 32'h90, 32'hD0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_full_stall", if_stall, 0);
    chk("flush_full_count", count, 0);

    // Mid-operation reset beats flush and push
    cyc(1'b1, 32'h50, 32'hE0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h54, 32'hE4, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("premid_count", count, 2);
    cyc(1'b1, 32'h58, 32'hE8, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("midrst_count", count, 0);
    chk("midrst_stall", if_stall, 0);
    chk("midrst_valid", id_valid, 0);
    chk("midrst_head", {id_pc, id_insn}, 64'h0);
    cyc(1'b1, 32'h60, 32'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h64, 32'hF4, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("postrst_count", count, 2);
    chk("postrst_head", {id_pc, id_insn}, {32'h60, 32'hF0});
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    chk("end_count", count, 0);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
